// File: rtl/exme_pipe_reg.sv
// EX->ME pipeline register: valid/ready handshake, optional one-entry skid buffer,
// synchronous flush to bubble, and a saturating count of bubble cycles.
module exme_pipe_reg #(
    parameter int DATA_W = 32,
    parameter int RW_W   = 5,
    parameter int CTRL_W = 3,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset_0,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] ans_ex,
    input  logic [DATA_W-1:0] b_ex,
    input  logic [RW_W-1:0]   rw_ex,
    input  logic [CTRL_W-1:0] ctrl_ex,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] ans_me,
    output logic [DATA_W-1:0] b_me,
    output logic [RW_W-1:0]   rw_me,
    output logic [CTRL_W-1:0] ctrl_me,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  bubble_cnt
);

    localparam int PW = 2 * DATA_W + RW_W + CTRL_W;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t            state_r;
    logic [PW-1:0]     main_r;
    logic [PW-1:0]     skid_r;
    logic              out_valid_r;
    logic              in_ready_r;
    logic [1:0]        occ_r;
    logic [CNT_W-1:0]  bubble_cnt_r;

    logic [PW-1:0]     payload_s;
    logic              accept_s;
    logic              consume_s;

    assign payload_s = {ans_ex, b_ex, rw_ex, ctrl_ex};

    // Without a skid entry the stage frees up in the same cycle ME consumes.
    assign in_ready  = (SKID != 0) ? in_ready_r : (!out_valid_r || out_ready);
    assign accept_s  = in_valid && in_ready;
    assign consume_s = out_valid_r && out_ready;

    // Occupancy FSM; payload registers are zeroed whenever they go invalid so the
    // ME outputs are clean bubbles without any output gating.
    always_ff @(posedge clock or negedge reset_0) begin
        if (!reset_0) begin
            state_r     <= ST_EMPTY;
            main_r      <= {PW{1'b0}};
            skid_r      <= {PW{1'b0}};
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            occ_r       <= 2'd0;
        end else if (flush) begin
            state_r     <= ST_EMPTY;
            main_r      <= {PW{1'b0}};
            skid_r      <= {PW{1'b0}};
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            occ_r       <= 2'd0;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (accept_s) begin
                        main_r      <= payload_s;
                        out_valid_r <= 1'b1;
                        occ_r       <= 2'd1;
                        state_r     <= ST_ONE;
                    end else begin
                        state_r     <= ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (accept_s && consume_s) begin
                        main_r      <= payload_s;
                    end else if (consume_s) begin
                        main_r      <= {PW{1'b0}};
                        out_valid_r <= 1'b0;
                        occ_r       <= 2'd0;
                        state_r     <= ST_EMPTY;
                    end else if (accept_s && (SKID != 0)) begin
                        skid_r      <= payload_s;
                        in_ready_r  <= 1'b0;
                        occ_r       <= 2'd2;
                        state_r     <= ST_TWO;
                    end else begin
                        state_r     <= ST_ONE;
                    end
                end
                ST_TWO: begin
                    if (consume_s) begin
                        main_r      <= skid_r;
                        skid_r      <= {PW{1'b0}};
                        in_ready_r  <= 1'b1;
                        occ_r       <= 2'd1;
                        state_r     <= ST_ONE;
                    end else begin
                        state_r     <= ST_TWO;
                    end
                end
                default: begin
                    state_r     <= ST_EMPTY;
                    main_r      <= {PW{1'b0}};
                    skid_r      <= {PW{1'b0}};
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    occ_r       <= 2'd0;
                end
            endcase
        end
    end

    // Bubble counter: counts edges where ME saw no valid entry; flush leaves it alone.
    always_ff @(posedge clock or negedge reset_0) begin
        if (!reset_0) begin
            bubble_cnt_r <= {CNT_W{1'b0}};
        end else if (!out_valid_r && (bubble_cnt_r != {CNT_W{1'b1}})) begin
            bubble_cnt_r <= bubble_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            bubble_cnt_r <= bubble_cnt_r;
        end
    end

    assign {ans_me, b_me, rw_me, ctrl_me} = main_r;
    assign out_valid  = out_valid_r;
    assign occupancy  = occ_r;
    assign bubble_cnt = bubble_cnt_r;

endmodule
